// File: rtl/des_match_collector_if.sv
// Result/message stream carrying a valid/ready handshake.
// Used for both the DES input side and the FIFO readout side.
interface des_match_collector_if #(
  parameter int N = 32,
  parameter int W = 64
);
  logic         valid;
  logic [N-1:0] message;
  logic [W-1:0] result;
  logic         ready;

  modport master (
    output valid, message, result,
    input  ready
  );

  modport slave (
    input  valid, message, result,
    output ready
  );
endinterface

// File: rtl/des_match_collector.sv
// Masked-match filter on DES results, buffered in a FWFT FIFO,
// with LFSR back-pressure and run/drain/complete sequencing.
module des_match_collector #(
  parameter int N            = 32,
  parameter int W            = 64,
  parameter int DEPTH        = 8,
  parameter int PAUSE_MARGIN = 4,
  parameter int PIPE_LAT     = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic [W-1:0]          target,
  input  logic [W-1:0]          mask,
  des_match_collector_if.slave  in_s,
  des_match_collector_if.master out_m,
  input  logic                  src_done,
  output logic                  pause,
  output logic [N-1:0]          match_count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam int EW = N + W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  target_q, target_d;
  logic [W-1:0]  mask_q, mask_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          eval;
  logic          hit;
  logic          pop;
  logic          push;
  logic          full;
  logic          flush;
  logic          arm;
  logic [CW-1:0] free;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start) state_d = S_RUN;
        S_RUN:   if (src_done) state_d = S_DRAIN;
        S_DRAIN: begin
          if (drain_q == '0 && occ_d == '0)
            state_d = S_DONE;
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy  = (state_q == S_RUN) ||
            (state_q == S_DRAIN);
    done  = (state_q == S_DONE);
    free  = CW'(DEPTH) - occ_q;
    pause = busy &&
            (free <= CW'(PAUSE_MARGIN));
  end

  // Match / FIFO control
  always_comb begin
    full  = (occ_q == CW'(DEPTH));
    eval  = (state_q == S_RUN) ||
            ((state_q == S_DRAIN) &&
             (drain_q != '0));
    hit   = eval && in_s.valid &&
            (((in_s.result ^ target_q) &
              mask_q) == '0);
    pop   = (occ_q != '0) && out_m.ready;
    push  = hit && (!full || pop);
    arm   = (state_q == S_IDLE) && start;
    flush = clear || arm;
  end

  always_comb begin
    target_d = target_q;
    mask_d   = mask_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    drain_d  = drain_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      drain_d  = '0;
      if (!clear) begin
        target_d = target;
        mask_d   = mask;
      end
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {in_s.message,
                           in_s.result};
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + CW'(1);
        2'b01:   occ_d = occ_q - CW'(1);
        default: occ_d = occ_q;
      endcase
      if (hit && (cnt_q != '1))
        cnt_d = cnt_q + N'(1);
      if (hit && !push) ovf_d = 1'b1;
      // Drain window covers results still in the DES pipe
      if ((state_q == S_RUN) && src_done)
        drain_d = DW'(PIPE_LAT);
      else if ((state_q == S_DRAIN) &&
               (drain_q != '0))
        drain_d = drain_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
      mask_q   <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      drain_q  <= '0;
    end else begin
      target_q <= target_d;
      mask_q   <= mask_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      drain_q  <= drain_d;
    end
  end

  assign in_s.ready    = eval;
  assign out_m.valid   = (occ_q != '0);
  assign out_m.message = mem_q[rd_ptr_q][EW-1:W];
  assign out_m.result  = mem_q[rd_ptr_q][W-1:0];
  assign match_count   = cnt_q;
  assign overflow      = ovf_q;

endmodule

// File: doc/des_match_collector.md
Name: des_match_collector

Overview:
- Sits directly downstream of the DES core that encrypts the LFSR-generated messages.
- Compares each DES result against a masked target pattern and buffers matching {message, result} pairs in a small first-word-fall-through FIFO for the readout logic.
- Drives the LFSR pause input when the buffer nears full.
- Signals completion once the LFSR reports done, the DES pipeline has drained, and every match has been read out.

Parameters:
N, 32, message width (equals the LFSR width)
W, 64, DES result width
DEPTH, 8, FIFO entries (power of 2, >=4)
PAUSE_MARGIN, 4, pause asserted when free slots <= PAUSE_MARGIN (covers LFSR and DES reaction latency)
PIPE_LAT, 17, DES pipeline latency in cycles; drain window after src_done

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  arm block: latch target and mask; honoured in IDLE only
clear  in  1  return to IDLE from any state; flush FIFO, counters, flags
target  in  W  match pattern, sampled on start
mask  in  W  bit mask (1 = compare bit), sampled on start
in_valid  in  1  DES result valid this cycle
in_message  in  N  plaintext/LFSR value belonging to in_result
in_result  in  W  DES ciphertext
src_done  in  1  LFSR done level
pause  out  1  back-pressure to the LFSR pause input
out_valid  out  1  FIFO non-empty
out_message  out  N  head entry message
out_result  out  W  head entry result
out_ready  in  1  consumer accepts head when out_valid=1
match_count  out  N  total matches seen (stored and dropped), saturating
overflow  out  1  sticky: a match was dropped because the FIFO was full
busy  out  1  state is RUNNING or DRAINING
done  out  1  state is COMPLETE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; FIFO empty.
  - pause, out_valid, match_count, overflow, busy and done are all 0; out_message and out_result are 0.
  - target_reg and mask_reg are 0.
- States: IDLE, RUNNING, DRAINING, COMPLETE.
- Priority: clear > start > everything else.
- IDLE:
  - in_valid ignored.
  - On start=1: target_reg<=target, mask_reg<=mask, FIFO flushed, match_count<=0, overflow<=0; next state RUNNING.
- Match definition: in_valid=1 and ((in_result ^ target_reg) & mask_reg)==0.
  - mask_reg=0 means every valid input matches.
- RUNNING / DRAINING, each match:
  - match_count increments, saturating at all-ones.
  - If FIFO not full, or a pop occurs in the same cycle: push {in_message, in_result}.
  - Otherwise: entry dropped, overflow<=1.
- RUNNING -> DRAINING when src_done=1.
  - An input in that same cycle is still evaluated.
  - Drain counter is loaded with PIPE_LAT.
- DRAINING:
  - Inputs are still evaluated while the counter is nonzero; the counter decrements by 1 per cycle.
  - Once the counter is 0, in_valid is ignored.
  - Go to COMPLETE in the first cycle where the counter is 0 and the FIFO is empty, including after the final pop.
- COMPLETE: done=1; in_valid and start ignored; clear -> IDLE.
- clear in any state: next state IDLE, FIFO flushed, match_count=0, overflow=0 (registered, one cycle).
- FIFO:
  - First-word fall-through: head is visible on out_message/out_result whenever out_valid=1.
  - Pop when out_valid & out_ready.
  - Output values are undefined (held) when empty.
  - Occupancy counter is 0..DEPTH; read and write pointers wrap modulo DEPTH.
  - Simultaneous push+pop keeps occupancy unchanged (legal when full and when empty).
  - Push+pop when empty: head updates the next cycle, with no bypass.
- pause = busy & ((DEPTH - occupancy) <= PAUSE_MARGIN).
  - Derived only from registered state and occupancy, so it is glitch-free.
  - Forced 0 in IDLE and COMPLETE.
- match_count counts only while busy and holds its value in COMPLETE.
- Latency: match at edge k -> out_valid=1 after edge k when the FIFO was empty.

Test Plan:
- Basic match: start with target=64'h0123_4567_89AB_CDEF, mask=all-ones; drive 10 inputs, only the 4th matching (message=32'h5) -> out_valid the cycle after, out_message=5, match_count=1, overflow=0.
- Mask: mask=64'h0000_0000_0000_00FF, target=64'h...3C; results ending 0x3C on 3 of 20 inputs -> exactly 3 FIFO entries, match_count=3.
- Back-pressure/overflow: DEPTH=8, mask=0, out_ready=0, in_valid every cycle:
  - pause rises once occupancy=4.
  - After 12 valid inputs: occupancy=8, match_count=12, overflow=1.
  - Popping 8 entries returns the first 8 messages in order.
- Full with simultaneous push+pop: FIFO full, out_ready=1, matching input -> occupancy stays 8, no overflow, new entry at tail.
- Completion: src_done=1 while 2 entries are held; a match arrives 5 cycles later:
  - The match is stored (inside PIPE_LAT).
  - A match 20 cycles later is ignored.
  - done=1 the cycle after the last pop.
  - clear -> IDLE with match_count=0.
- Async reset mid-DRAINING: rst_n low between edges -> done, busy, pause and out_valid go to 0 immediately, with no clock edge needed.
